// File: rtl/conv_result_collector_if.sv
// Result collector bus: convolver-side strobe, drain handshake, status.
// master = result source / downstream sink, slave = the collector.
interface conv_result_collector_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5
);
    localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int RC_W = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;

    logic                         clear;
    logic                         in_enable;
    logic signed [DATA_WIDTH-1:0] in_result;
    logic                         rd_ready;
    logic                         rd_valid;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic                         rd_last;
    logic                         frame_done;
    logic                         busy;
    logic                         overflow;
    logic [RC_W-1:0]              wr_row;
    logic [RC_W-1:0]              wr_col;

    modport master (
        output clear, in_enable, in_result, rd_ready,
        input  rd_valid, rd_data, rd_last, frame_done,
        input  busy, overflow, wr_row, wr_col
    );

    modport slave (
        input  clear, in_enable, in_result, rd_ready,
        output rd_valid, rd_data, rd_last, frame_done,
        output busy, overflow, wr_row, wr_col
    );
endinterface

// File: rtl/conv_result_collector.sv
// Collects convolver results into an OUT_SIZE^2 map (optional ReLU),
// then drains it in raster order. Ports: clk, reset (async, low), bus.
module conv_result_collector #(
    parameter int DATA_WIDTH  = 16,
    parameter int IMAGE_SIZE  = 28,
    parameter int KERNEL_SIZE = 5,
    parameter bit RELU_EN     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    conv_result_collector_if.slave bus
);
    localparam int OUT_SIZE = IMAGE_SIZE - KERNEL_SIZE + 1;
    localparam int N        = OUT_SIZE * OUT_SIZE;
    localparam int RC_W     = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
    localparam int PTR_W    = (N > 1) ? $clog2(N) : 1;

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(OUT_SIZE - 1);
    localparam logic [RC_W-1:0]  RC_ONE   = RC_W'(1);

    typedef enum logic {COLLECT, DRAIN} state_t;

    state_t                state_q, state_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [RC_W-1:0]       wr_row_q, wr_row_d;
    logic [RC_W-1:0]       wr_col_q, wr_col_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_last_q, rd_last_d;
    logic                  frame_done_q, frame_done_d;
    logic                  overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0] mem [N];
    logic [DATA_WIDTH-1:0] wr_val;
    logic [PTR_W-1:0]      rd_ptr_nx;
    logic                  wr_fire;

    assign wr_fire   = (state_q == COLLECT) && bus.in_enable && !bus.clear;
    assign wr_val    = (RELU_EN && bus.in_result[DATA_WIDTH-1])
                     ? '0 : bus.in_result;
    assign rd_ptr_nx = rd_ptr_q + PTR_ONE;

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_val;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= COLLECT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wr_row_q     <= '0;
            wr_col_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rd_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_row_q     <= wr_row_d;
            wr_col_q     <= wr_col_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rd_last_q    <= rd_last_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wr_row_d     = wr_row_q;
        wr_col_d     = wr_col_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        rd_last_d    = rd_last_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        if (bus.clear) begin
            state_d    = COLLECT;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            wr_row_d   = '0;
            wr_col_d   = '0;
            rd_valid_d = 1'b0;
            rd_data_d  = '0;
            rd_last_d  = 1'b0;
            overflow_d = 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    if (bus.in_enable) begin
                        if (wr_ptr_q == LAST_PTR) begin
                            wr_ptr_d     = '0;
                            wr_row_d     = '0;
                            wr_col_d     = '0;
                            frame_done_d = 1'b1;
                            state_d      = DRAIN;
                        end else begin
                            wr_ptr_d = wr_ptr_q + PTR_ONE;
                            if (wr_col_q == LAST_RC) begin
                                wr_col_d = '0;
                                wr_row_d = wr_row_q + RC_ONE;
                            end else begin
                                wr_col_d = wr_col_q + RC_ONE;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (bus.in_enable) begin
                        overflow_d = 1'b1;
                    end
                    // First DRAIN cycle primes the output register.
                    if (!rd_valid_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = mem[rd_ptr_q];
                        rd_last_d  = (rd_ptr_q == LAST_PTR);
                    end else if (bus.rd_ready) begin
                        if (rd_last_q) begin
                            state_d    = COLLECT;
                            rd_ptr_d   = '0;
                            rd_valid_d = 1'b0;
                            rd_data_d  = '0;
                            rd_last_d  = 1'b0;
                        end else begin
                            rd_ptr_d  = rd_ptr_nx;
                            rd_data_d = mem[rd_ptr_nx];
                            rd_last_d = (rd_ptr_nx == LAST_PTR);
                        end
                    end
                end
                default: state_d = COLLECT;
            endcase
        end
    end

    always_comb begin
        bus.rd_valid   = rd_valid_q;
        bus.rd_data    = rd_data_q;
        bus.rd_last    = rd_last_q;
        bus.frame_done = frame_done_q;
        bus.busy       = (state_q == DRAIN);
        bus.overflow   = overflow_q;
        bus.wr_row     = wr_row_q;
        bus.wr_col     = wr_col_q;
    end
endmodule
